// File: rtl/layer_compositor.sv
// Depth-sorted compositor: players over object grid over floor. 2-cycle pixel/sync latency.
// Free-running pixel stream with no backpressure; ranks are re-sorted once per frame.
module layer_compositor #(
  parameter int                 NUM_PLAYERS = 4,
  parameter int                 PIXEL_W     = 12,
  parameter int                 Y_W         = 9,
  parameter logic [PIXEL_W-1:0] KEY         = 12'hFFF
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_PLAYERS-1:0]         layer_enable,
  input  logic [NUM_PLAYERS*Y_W-1:0]     player_y,
  input  logic [NUM_PLAYERS*PIXEL_W-1:0] player_pixel,
  input  logic [PIXEL_W-1:0]             object_pixel,
  input  logic [PIXEL_W-1:0]             floor_pixel,
  input  logic                           hsync,
  input  logic                           vsync,
  input  logic                           blank,
  output logic                           hsync_out,
  output logic                           vsync_out,
  output logic                           blank_out,
  output logic [PIXEL_W-1:0]             pixel_out,
  output logic                           sort_busy
);
  localparam int K_W = $clog2(NUM_PLAYERS + 1);

  typedef enum logic {IDLE, SORT} state_t;

  state_t                 state_q;
  logic [K_W-1:0]         k_q;
  logic                   vsync_prev_q;
  logic [NUM_PLAYERS-1:0] shadow_en_q;
  logic [Y_W-1:0]         shadow_y_q [NUM_PLAYERS];
  logic [K_W-1:0]         pend_q     [NUM_PLAYERS];
  logic [K_W-1:0]         act_q      [NUM_PLAYERS];

  logic                   frame_start;
  logic [K_W-1:0]         rank_d;
  int                     kk;

  assign frame_start = vsync_prev_q && !vsync;
  assign sort_busy   = (state_q == SORT);

  // Rank of layer kk: number of enabled layers drawn in front of it.
  always_comb begin
    kk     = (int'(k_q) < NUM_PLAYERS) ? int'(k_q) : 0;
    rank_d = '0;
    for (int j = 0; j < NUM_PLAYERS; j++) begin
      if (j != kk && shadow_en_q[j] &&
          (shadow_y_q[j] > shadow_y_q[kk] ||
           (shadow_y_q[j] == shadow_y_q[kk] && j < kk)))
        rank_d = rank_d + K_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      k_q          <= '0;
      vsync_prev_q <= 1'b1;
      shadow_en_q  <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        shadow_y_q[i] <= '0;
        pend_q[i]     <= K_W'(i);
        act_q[i]      <= K_W'(i);
      end
    end else begin
      vsync_prev_q <= vsync;
      if (frame_start) begin
        shadow_en_q <= layer_enable;
        for (int i = 0; i < NUM_PLAYERS; i++)
          shadow_y_q[i] <= player_y[i*Y_W +: Y_W];
        state_q <= SORT;
        k_q     <= '0;
      end else if (state_q == SORT) begin
        // k == NUM_PLAYERS is the commit cycle: publish the whole table at once.
        if (k_q == K_W'(NUM_PLAYERS)) begin
          for (int i = 0; i < NUM_PLAYERS; i++)
            act_q[i] <= pend_q[i];
          state_q <= IDLE;
          k_q     <= '0;
        end else begin
          pend_q[kk] <= rank_d;
          k_q        <= k_q + K_W'(1);
        end
      end
    end
  end

  logic [NUM_PLAYERS-1:0] hit_q;
  logic [PIXEL_W-1:0]     ppix_q [NUM_PLAYERS];
  logic [PIXEL_W-1:0]     obj_q, floor_q;
  logic                   hsync_q, vsync_q, blank_q;
  logic                   found;
  logic [K_W-1:0]         best_rank;
  logic [PIXEL_W-1:0]     best_pix, pixel_d;

  always_comb begin
    found     = 1'b0;
    best_rank = '0;
    best_pix  = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (hit_q[i] && (!found || act_q[i] < best_rank)) begin
        found     = 1'b1;
        best_rank = act_q[i];
        best_pix  = ppix_q[i];
      end
    end
    if (blank_q)            pixel_d = '0;
    else if (found)         pixel_d = best_pix;
    else if (obj_q != KEY)  pixel_d = obj_q;
    else                    pixel_d = floor_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q     <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) ppix_q[i] <= '0;
      obj_q     <= '0;
      floor_q   <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_q   <= 1'b1;
      pixel_out <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      blank_out <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        hit_q[i]  <= shadow_en_q[i] && (player_pixel[i*PIXEL_W +: PIXEL_W] != KEY);
        ppix_q[i] <= player_pixel[i*PIXEL_W +: PIXEL_W];
      end
      obj_q     <= object_pixel;
      floor_q   <= floor_pixel;
      hsync_q   <= hsync;
      vsync_q   <= vsync;
      blank_q   <= blank;
      pixel_out <= pixel_d;
      hsync_out <= hsync_q;
      vsync_out <= vsync_q;
      blank_out <= blank_q;
    end
  end

endmodule
